beat_interval_averager: RTL and testbench

Smooths the beat-to-beat interval produced by the interval counter/register chain before it reaches the period-to-BPM ROM. On every beat strobe it accepts or rejects the captured interval against a physiological window, keeps a running 4-beat moving average, and flags irregular rhythm and loss of pulse. `avg_out` replaces the raw register value as the ROM address source; the status flags feed the LED/speaker controllers.

---
 rtl/beat_interval_averager_if.sv | 33 +++
 rtl/beat_interval_averager.sv | 197 +++++++++++++++++++
 tb/tb_beat_interval_averager.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/beat_interval_averager_if.sv
// Beat-path bundle between the pulse finder / interval register chain
// (master side) and the interval averager (slave side).
interface beat_interval_averager_if #(
  parameter int W = 11
);
  logic         z;
  logic [W-1:0] period_in;
  logic [W-1:0] avg_out;
  logic         avg_valid;
  logic         beat_ok;
  logic         irregular;
  logic         lost;

  modport master (
    output z,
    output period_in,
    input  avg_out,
    input  avg_valid,
    input  beat_ok,
    input  irregular,
    input  lost
  );

  modport slave (
    input  z,
    input  period_in,
    output avg_out,
    output avg_valid,
    output beat_ok,
    output irregular,
    output lost
  );
endinterface

// File: rtl/beat_interval_averager.sv
// Beat interval averager: validates each captured beat interval against a
// physiological window, keeps a DEPTH-beat moving average for the
// period-to-BPM ROM address, and flags irregular rhythm and loss of pulse.
// All outputs are registered and follow the internal state by one cycle.
module beat_interval_averager #(
  parameter int W          = 11,
  parameter int DEPTH      = 4,     // power of 2, at least 2
  parameter int MIN_PERIOD = 300,
  parameter int MAX_PERIOD = 1500,
  parameter int TIMEOUT    = 3000,
  parameter int REJ_LIMIT  = 3
) (
  input  logic                       clk,
  input  logic                       start,
  beat_interval_averager_if.slave    bus
);

  localparam int LOG2 = $clog2(DEPTH);
  localparam int SW   = W + LOG2;
  localparam int FW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(TIMEOUT + 1);
  localparam int RW   = $clog2(REJ_LIMIT + 1);

  localparam logic [W-1:0]  MIN_P     = W'(MIN_PERIOD);
  localparam logic [W-1:0]  MAX_P     = W'(MAX_PERIOD);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [RW-1:0] REJ_MAX   = RW'(REJ_LIMIT);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILLING,
    S_TRACKING,
    S_LOST
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Window storage and bookkeeping
  logic [DEPTH-1:0][W-1:0] w_buf;
  logic [DEPTH-1:0]        w_wr_en;
  logic [LOG2-1:0]         r_wr_ptr;
  logic [FW-1:0]           r_fill;
  logic [SW-1:0]           r_sum;
  logic [IW-1:0]           r_idle;
  logic [RW-1:0]           r_rej;
  logic                    r_acc;

  // Registered outputs
  logic [W-1:0]            r_avg_out;
  logic                    r_avg_valid;
  logic                    r_beat_ok;
  logic                    r_irregular;
  logic                    r_lost;

  // Per-beat decisions
  logic                    w_in_window;
  logic                    w_accept;
  logic                    w_reject;
  logic                    w_enter_lost;
  logic [W-1:0]            w_old;
  logic [SW-1:0]           w_sum_next;

  assign w_in_window = (bus.period_in >= MIN_P) && (bus.period_in <= MAX_P);

  // The entry about to be overwritten only contributes to the sum once the
  // window is full; before that the slot holds nothing meaningful.
  assign w_old      = (r_fill == FILL_FULL) ? w_buf[r_wr_ptr] : '0;
  assign w_sum_next = r_sum - SW'(w_old) + SW'(bus.period_in);

  // One register per window slot, each with its own write enable.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
    logic [W-1:0] r_entry;

    assign w_wr_en[gi] = w_accept && (r_wr_ptr == LOG2'(gi));
    assign w_buf[gi]   = r_entry;

    // Slot storage: cleared on reset and on pulse loss, written on accept.
    always_ff @(posedge clk) begin
      if (start || w_enter_lost) begin
        r_entry <= '0;
      end else if (w_wr_en[gi]) begin
        r_entry <= bus.period_in;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (start) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-beat decisions. A beat arriving on the very cycle
  // the idle counter would expire is processed and pre-empts the timeout.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_enter_lost = 1'b0;
    case (r_state)
      S_LOST: begin
        // The first beat after a dropout spans the gap, so it only re-arms.
        if (bus.z) begin
          w_state_next = S_EMPTY;
        end
      end
      default: begin
        if (bus.z) begin
          if (w_in_window) begin
            w_accept = 1'b1;
            if (r_state != S_TRACKING) begin
              w_state_next = (r_fill == FILL_LAST) ? S_TRACKING : S_FILLING;
            end
          end else begin
            w_reject = 1'b1;
          end
        end else if (r_idle == IDLE_LAST) begin
          w_enter_lost = 1'b1;
          w_state_next = S_LOST;
        end
      end
    endcase
  end

  // Window pointer, fill level and running sum.
  always_ff @(posedge clk) begin
    if (start || w_enter_lost) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_sum    <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      r_sum    <= w_sum_next;
      if (r_fill != FILL_FULL) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Idle counter: ticks since the last beat of any kind, saturating.
  always_ff @(posedge clk) begin
    if (start || bus.z) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_MAX) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  // Consecutive-reject counter, saturating; any accepted beat clears it.
  always_ff @(posedge clk) begin
    if (start || w_enter_lost || w_accept) begin
      r_rej <= '0;
    end else if (w_reject && (r_rej != REJ_MAX)) begin
      r_rej <= r_rej + 1'b1;
    end
  end

  // Accept marker, turned into the beat_ok strobe one cycle later.
  always_ff @(posedge clk) begin
    if (start) begin
      r_acc <= 1'b0;
    end else begin
      r_acc <= w_accept;
    end
  end

  // Output stage: registered view of the state settled at the previous edge.
  always_ff @(posedge clk) begin
    if (start) begin
      r_avg_out   <= '0;
      r_avg_valid <= 1'b0;
      r_beat_ok   <= 1'b0;
      r_irregular <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_avg_out   <= (r_state == S_TRACKING) ? r_sum[SW-1:LOG2] : '0;
      r_avg_valid <= (r_state == S_TRACKING);
      r_beat_ok   <= r_acc;
      r_irregular <= (r_rej == REJ_MAX);
      r_lost      <= (r_state == S_LOST);
    end
  end

  assign bus.avg_out   = r_avg_out;
  assign bus.avg_valid = r_avg_valid;
  assign bus.beat_ok   = r_beat_ok;
  assign bus.irregular = r_irregular;
  assign bus.lost      = r_lost;

endmodule

// File: tb/tb_beat_interval_averager.sv
// Bench for beat_interval_averager: directed scenarios followed by random
// beats, every cycle compared against a queue-based reference model.
module tb_beat_interval_averager;

  localparam int W          = 11;
  localparam int DEPTH      = 4;
  localparam int MIN_PERIOD = 300;
  localparam int MAX_PERIOD = 1500;
  localparam int TIMEOUT    = 3000;
  localparam int REJ_LIMIT  = 3;

  logic clk = 1'b0;
  logic start;

  beat_interval_averager_if #(.W(W)) bus ();

  beat_interval_averager #(
    .W(W), .DEPTH(DEPTH), .MIN_PERIOD(MIN_PERIOD), .MAX_PERIOD(MAX_PERIOD),
    .TIMEOUT(TIMEOUT), .REJ_LIMIT(REJ_LIMIT)
  ) dut (
    .clk(clk),
    .start(start),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ok_count = 0;

  // Reference model: the last DEPTH accepted intervals, plus counters.
  int q[$];
  bit m_lost = 1'b0;
  int m_rej  = 0;
  int m_idle = 0;
  bit m_acc  = 1'b0;

  // Expected outputs right after the current edge
  int e_avg   = 0;
  bit e_valid = 1'b0;
  bit e_ok    = 1'b0;
  bit e_irr   = 1'b0;
  bit e_lost  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit zz, input int p, input bit st);
    int s;
    if (st) begin
      e_avg = 0; e_valid = 0; e_ok = 0; e_irr = 0; e_lost = 0;
      q.delete();
      m_lost = 0; m_rej = 0; m_idle = 0; m_acc = 0;
      return;
    end
    // Outputs show what the previous edge left behind.
    s = 0;
    foreach (q[i]) s += q[i];
    e_valid = (q.size() == DEPTH);
    e_avg   = e_valid ? s / DEPTH : 0;
    e_ok    = m_acc;
    e_irr   = (m_rej == REJ_LIMIT);
    e_lost  = m_lost;
    m_acc   = 0;
    if (m_lost) begin
      if (zz) begin
        m_lost = 0;
        m_idle = 0;
      end
    end else if (zz) begin
      m_idle = 0;
      if (p >= MIN_PERIOD && p <= MAX_PERIOD) begin
        q.push_back(p);
        if (q.size() > DEPTH) void'(q.pop_front());
        m_rej = 0;
        m_acc = 1;
      end else if (m_rej < REJ_LIMIT) begin
        m_rej++;
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_lost = 1;
        q.delete();
        m_rej = 0;
      end
    end
  endtask

  task automatic cycle(input bit zz, input int p, input bit st);
    bus.z         = zz;
    bus.period_in = W'(p);
    start         = st;
    @(posedge clk);
    model_edge(zz, p, st);
    #1;
    if (bus.beat_ok === 1'b1) ok_count++;
    chk("avg_out",   bus.avg_out,   e_avg);
    chk("avg_valid", bus.avg_valid, e_valid);
    chk("beat_ok",   bus.beat_ok,   e_ok);
    chk("irregular", bus.irregular, e_irr);
    chk("lost",      bus.lost,      e_lost);
  endtask

  task automatic tick();
    cycle(1'b0, 0, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic beat(input int p);
    $display("beat t=%0t period=%0d", $time, p);
    cycle(1'b1, p, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok_base;
    int exp2[4];
    int bnd[4];
    int r;
    int p;
    int sel;

    exp2 = '{900, 950, 1000, 1000};
    bnd  = '{299, 300, 1500, 1501};
    bus.z = 1'b0;
    bus.period_in = '0;
    start = 1'b1;

    // Reset
    $display("reset");
    cycle(1'b0, 0, 1'b1);
    chk("rst_avg_out", bus.avg_out, 0);
    chk("rst_lost", bus.lost, 0);
    tick();

    // Four 800-tick beats fill the window
    ok_base = ok_count;
    for (int k = 0; k < 4; k++) begin
      beat(800);
      if (k < 3) gap(799);
    end
    chk("p1_valid_pre", bus.avg_valid, 0);
    tick();
    chk("p1_avg", bus.avg_out, 800);
    chk("p1_valid", bus.avg_valid, 1);
    chk("p1_okcount", ok_count - ok_base, 4);

    // Step to 1000 including pointer wrap
    gap(20); beat(1000); tick();
    chk("p2_avg0", bus.avg_out, 850);
    chk("p2_valid", bus.avg_valid, 1);
    for (int k = 0; k < 4; k++) begin
      gap(20); beat(1000); tick();
      chk("p2_avg", bus.avg_out, exp2[k]);
    end

    // Rejects raise irregular, an accept clears it
    for (int k = 0; k < 4; k++) begin
      gap(20); beat(800);
    end
    tick();
    chk("p3_avg_base", bus.avg_out, 800);
    for (int k = 0; k < 3; k++) begin
      gap(10); beat(200); tick();
      chk("p3_rej_ok", bus.beat_ok, 0);
      chk("p3_irr", bus.irregular, (k == 2) ? 1 : 0);
      chk("p3_avg", bus.avg_out, 800);
    end
    gap(10); beat(800); tick();
    chk("p3_irr_clear", bus.irregular, 0);
    chk("p3_ok", bus.beat_ok, 1);

    // Timeout: lost appears exactly 3001 cycles after the last beat
    gap(2999);
    chk("p4_lost_pre", bus.lost, 0);
    tick();
    chk("p4_lost", bus.lost, 1);
    chk("p4_valid", bus.avg_valid, 0);
    chk("p4_avg", bus.avg_out, 0);
    gap(5); beat(5); tick();
    chk("p4_lost_clear", bus.lost, 0);
    chk("p4_no_ok", bus.beat_ok, 0);
    for (int k = 0; k < 4; k++) begin
      gap(20); beat(800); tick();
      chk("p4_refill_valid", bus.avg_valid, (k == 3) ? 1 : 0);
    end

    // Beat on the expiring tick wins over the timeout
    gap(2998); beat(900); tick();
    chk("p5_lost", bus.lost, 0);
    chk("p5_ok", bus.beat_ok, 1);
    chk("p5_avg", bus.avg_out, 825);
    gap(5);
    chk("p5_lost_later", bus.lost, 0);

    // Reset coincident with a beat
    gap(10);
    $display("reset with z");
    cycle(1'b1, 800, 1'b1);
    chk("p6_avg", bus.avg_out, 0);
    chk("p6_valid", bus.avg_valid, 0);
    chk("p6_ok", bus.beat_ok, 0);
    gap(3); beat(800); tick();
    chk("p6_single_valid", bus.avg_valid, 0);
    chk("p6_single_ok", bus.beat_ok, 1);

    // Window boundaries
    gap(5); beat(299); tick(); chk("b_299", bus.beat_ok, 0);
    gap(5); beat(1501); tick(); chk("b_1501", bus.beat_ok, 0);
    gap(5); beat(300); tick(); chk("b_300", bus.beat_ok, 1);
    gap(5); beat(1500); tick(); chk("b_1500", bus.beat_ok, 1);
    gap(5); beat(1000); tick();
    chk("b_avg", bus.avg_out, 900);
    chk("b_valid", bus.avg_valid, 1);

    // Random beats
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(99, 0);
      if (r < 2) begin
        gap($urandom_range(TIMEOUT + 5, TIMEOUT - 5));
      end else if (r < 4) begin
        $display("reset with z");
        cycle(1'b1, 800, 1'b1);
      end else if (r >= 12) begin
        gap($urandom_range(30, 1));
      end
      sel = $urandom_range(9, 0);
      case (sel)
        0:       p = $urandom_range(MIN_PERIOD - 1, 0);
        1:       p = $urandom_range(2047, MAX_PERIOD + 1);
        2:       p = bnd[$urandom_range(3, 0)];
        default: p = $urandom_range(MAX_PERIOD, MIN_PERIOD);
      endcase
      beat(p);
    end
    gap(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
